// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the RV32M operations.
// One operand pair is processed at a time through IDLE -> PREP -> CALC -> FIX -> DONE.
// A 32-step shift-add multiplier and a 32-step restoring divider share one 64-bit accumulator.
module mult_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [2:0]            mdu_op_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    input  logic                  kill_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    localparam int unsigned W   = DATA_WIDTH;
    localparam int unsigned AW  = 2 * DATA_WIDTH;
    localparam int unsigned CW  = 6;
    localparam logic [CW-1:0] ITER     = CW'(W);
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e          state_q,   state_d;
    logic [2:0]      op_q,      op_d;
    logic [W-1:0]    a_q,       a_d;
    logic [W-1:0]    b_q,       b_d;
    logic [W-1:0]    mcand_q,   mcand_d;
    logic [AW-1:0]   acc_q,     acc_d;
    logic            neg_q,     neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [W-1:0]    result_q,  result_d;
    logic            valid_q,   valid_d;
    logic            busy_q,    busy_d;

    // Operand conditioning signals used in PREP
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [W-1:0]    special_res;

    // Iteration step signals used in CALC
    logic [W:0]      mul_sum;
    logic [W:0]      mul_add;
    logic [AW-1:0]   mul_next;
    logic [W:0]      div_shift;
    logic            div_ge;
    logic [W-1:0]    div_trial;
    logic [W-1:0]    div_rem;
    logic [AW-1:0]   div_next;

    // Sign correction signals used in FIX
    logic [AW-1:0]   prod_fix;
    logic [W-1:0]    quo_raw;
    logic [W-1:0]    rem_raw;
    logic [W-1:0]    fix_res;

    // Operand signedness, magnitudes and the results that bypass the iteration
    always_comb begin
        is_div   = op_q[2];
        a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                   (op_q == OP_DIV)  || (op_q == OP_REM);
        b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        a_neg    = a_signed & a_q[W-1];
        b_neg    = b_signed & b_q[W-1];
        a_mag    = a_neg ? (-a_q) : a_q;
        b_mag    = b_neg ? (-b_q) : b_q;
        div_zero = is_div && (b_q == '0);
        div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                   (a_q == MIN_NEG) && (b_q == ALL_ONES);

        special_res = '0;
        if (div_zero) begin
            // Quotient saturates to all ones; remainder is the dividend
            special_res = op_q[1] ? a_q : ALL_ONES;
        end else if (div_ovf) begin
            // Most-negative / -1 wraps back to itself with zero remainder
            special_res = op_q[1] ? '0 : MIN_NEG;
        end
    end

    // One shift-add multiply step and one restoring divide step on the accumulator
    always_comb begin
        // Multiply: acc = {partial high, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[AW-1:W]} + {1'b0, mcand_q};
        mul_add  = acc_q[0] ? mul_sum : {1'b0, acc_q[AW-1:W]};
        mul_next = {mul_add, acc_q[W-1:1]};

        // Divide: acc = {partial remainder, dividend bits becoming quotient bits}
        div_shift = acc_q[AW-1:W-1];
        div_ge    = div_shift >= {1'b0, mcand_q};
        div_trial = div_shift[W-1:0] - mcand_q;
        div_rem   = div_ge ? div_trial : div_shift[W-1:0];
        div_next  = {div_rem, acc_q[W-2:0], div_ge};
    end

    // Sign fix-up and result selection once the iteration is complete
    always_comb begin
        prod_fix = neg_q ? (-acc_q) : acc_q;
        quo_raw  = acc_q[W-1:0];
        rem_raw  = acc_q[AW-1:W];
        unique case (op_q)
            OP_MUL:                       fix_res = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[AW-1:W];
            OP_DIV, OP_DIVU:              fix_res = neg_q ? (-quo_raw) : quo_raw;
            OP_REM, OP_REMU:              fix_res = rem_neg_q ? (-rem_raw) : rem_raw;
            default:                      fix_res = '0;
        endcase
    end

    // Next-state and next-output logic for the sequencer
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        valid_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A simultaneous kill suppresses acceptance
                if (start_i && !kill_i) begin
                    op_d    = mdu_op_i;
                    a_d     = operand_a_i;
                    b_d     = operand_b_i;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else if (div_zero || div_ovf) begin
                    result_d = special_res;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    if (is_div) begin
                        mcand_d   = b_mag;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                    end else begin
                        mcand_d   = a_mag;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = 1'b0;
                    end
                    acc_d   = {{W{1'b0}}, is_div ? a_mag : b_mag};
                    cnt_d   = ITER;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div ? div_next : mul_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_res;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // The valid pulse is already out; kill has nothing left to cancel
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign result_o = result_q;
    assign valid_o  = valid_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  mdu_op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        kill_i;
    logic [31:0] result_o;
    logic        valid_o;
    logic        busy_o;

    int          checks;
    int          errors;
    logic [31:0] last_res;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .mdu_op_i    (mdu_op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .kill_i      (kill_i),
        .result_o    (result_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        int          q;
        sa = longint'({{32{a[31]}}, a});
        sb = longint'({{32{b[31]}}, b});
        ub = longint'({32'h0, b});
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = $signed(a) / $signed(b);
                return 32'(q);
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = $signed(a) % $signed(b);
                return 32'(q);
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Reference latency: divide-by-zero and signed overflow short-circuit
    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && b == 32'h0) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation from an IDLE cycle and check result, latency and pulse width.
    // Acceptance happens at edge T; valid first seen just after edge T+n lies in cycle T+n+1.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit ign, input string tag);
        int n;
        bit seen;
        start_i     = 1'b1;
        mdu_op_i    = op;
        operand_a_i = a;
        operand_b_i = b;
        @(posedge clk); #1;
        start_i     = 1'b0;
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        mdu_op_i    = 3'($urandom);
        chk({tag, "_busy"}, 64'(busy_o), 64'(1));
        chk({tag, "_hold"}, 64'(result_o), 64'(last_res));
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 60) begin
            n++;
            if (ign && n == 5) begin
                start_i     = 1'b1;
                mdu_op_i    = 3'd5;
                operand_a_i = 32'd100;
                operand_b_i = 32'd0;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            if (valid_o === 1'b1) seen = 1'b1;
        end
        chk({tag, "_lat"}, 64'(n + 1), 64'(lat));
        chk({tag, "_res"}, 64'(result_o), 64'(exp));
        last_res = exp;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(valid_o), 64'(0));
        chk({tag, "_idle"}, 64'(busy_o), 64'(0));
    endtask

    // Start an operation, then abort it with reset or kill just before edge T+k
    task automatic abort_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit use_rst, input int k, input string tag);
        int pulses;
        start_i     = 1'b1;
        mdu_op_i    = op;
        operand_a_i = a;
        operand_b_i = b;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (k - 1) @(posedge clk);
        #1;
        if (use_rst) rst_i = 1'b1;
        else         kill_i = 1'b1;
        @(posedge clk); #1;
        rst_i  = 1'b0;
        kill_i = 1'b0;
        if (use_rst) last_res = 32'h0;
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_valid"}, 64'(valid_o), 64'(0));
        chk({tag, "_res"}, 64'(result_o), 64'(last_res));
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o === 1'b1) pulses++;
        end
        chk({tag, "_nopulse"}, 64'(pulses), 64'(0));
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        checks      = 0;
        errors      = 0;
        last_res    = 32'h0;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        kill_i      = 1'b0;
        mdu_op_i    = 3'd0;
        operand_a_i = 32'h0;
        operand_b_i = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", 64'(result_o), 64'(0));
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Multiply corner values
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1'b0, "mul");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 1'b0, "mulh");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1'b0, "mulhu");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 1'b0, "mulhsu");

        // Divide corner values
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b0, "div");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1'b0, "rem");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 35, 1'b0, "divu");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, 35, 1'b0, "remu");
        do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0, "divu_z");
        do_op(3'd7, 32'd5, 32'd0, 32'd5, 2, 1'b0, "remu_z");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 1'b0, "rem_ovf");

        // Start pulse mid-operation is ignored; next op follows back-to-back
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1'b1, "mul_ign");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 35, 1'b0, "b2b");

        // Aborts: reset mid-CALC, kill in CALC, PREP (special op) and FIX
        abort_op(3'd4, 32'h1234_5678, 32'd3, 1'b1, 10, "rst_calc");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, 35, 1'b0, "after_rst");
        abort_op(3'd4, 32'h1234_5678, 32'd3, 1'b0, 10, "kill_calc");
        abort_op(3'd5, 32'd9, 32'd0, 1'b0, 1, "kill_prep");
        abort_op(3'd0, 32'd11, 32'd13, 1'b0, 34, "kill_fix");

        // Kill together with start in IDLE blocks acceptance
        start_i  = 1'b1;
        kill_i   = 1'b1;
        mdu_op_i = 3'd5;
        operand_a_i = 32'd1;
        operand_b_i = 32'd0;
        @(posedge clk); #1;
        start_i = 1'b0;
        kill_i  = 1'b0;
        chk("kill_start_busy", 64'(busy_o), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("kill_start_valid", 64'(valid_o), 64'(0));

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            if (sel == 3) a = 32'($urandom_range(0, 100));
            do_op(op, a, b, ref_res(op, a, b), ref_lat(op, a, b), 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
